// File: rtl/por_seq_pkg.sv
// Shared definitions for the power-on/restart sequencer.
//   por_state_t    : sequencer state type; the codes appear on POR_STATE.
//   retry_cnt_w()  : width of RETRY_CNT for a given MAX_RETRY.
//   lock_stage_w() : width of LOCK_STAGE for a given NPLL (never below 1).
package por_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_W4LOCK    = 4'd1,
    ST_POR_HOLD  = 4'd2,
    ST_CNFG      = 4'd3,
    ST_AUTO_LOAD = 4'd4,
    ST_ADC_INIT  = 4'd5,
    ST_RUN       = 4'd6,
    ST_FAULT     = 4'd7
  } por_state_t;

  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

  function automatic int lock_stage_w(input int npll);
    return (npll < 2) ? 1 : $clog2(npll);
  endfunction

endpackage

// File: rtl/por_sequencer_timer.sv
// Dwell/timeout timer shared by the lock-stage timeout and the POR hold.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over counting)
//   tc_val   : terminal-count compare value
//   tc       : high while the count equals tc_val
// The count saturates at all-ones so a long wait never wraps into a false
// terminal count.
module por_timer #(
  parameter int TW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic [TW-1:0] tc_val,
  output logic          tc
);

  logic [TW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (cnt != '1)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/por_sequencer.sv
// Power-on/restart sequencer: brings up NPLL clock sources in order, holds
// POR for POR_TMO cycles, then steps through PROM configuration, auto-load
// and ADC init before asserting RUN. Lock stages time out after LOCK_TMO
// cycles; MAX_RETRY timeouts are tolerated before a sticky fault.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   LOCK[NPLL]        : PLL lock flags (asynchronous, double-synchronised here)
//   BPI_SEQ_IDLE, AL_DONE, ADC_RDY, RESTART_ALL : synchronous level inputs
//   PLL_RST[NPLL]     : per-PLL reset
//   POR, ADC_INIT_RST, AL_START, RUN, FAULT     : sequencing outputs
//   RETRY_CNT         : timeouts since last Run/restart
//   LOCK_STAGE        : current (or faulting) lock stage
//   POR_STATE         : state code
// Optional feature: define POR_LOCK_MON_EN to return to Idle on any lock
// loss while in Run; otherwise LOCK is ignored in Run.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | all PLLs in reset, one cycle, then lock stage 0
// W4LOCK    | waiting for LOCK[stage]; lower stages must stay locked
// POR_HOLD  | all locked, POR held for POR_TMO cycles
// CNFG      | waiting for PROM sequencer idle
// AUTO_LOAD | AL_START high until AL_DONE
// ADC_INIT  | ADC init reset released, waiting for ADC_RDY
// RUN       | system running
// FAULT     | retries exhausted, sticky until RESTART_ALL
module por_sequencer
  import por_seq_pkg::*;
#(
  parameter int NPLL      = 2,
  parameter int TW        = 16,
  parameter int POR_TMO   = 120,
  parameter int LOCK_TMO  = 50000,
  parameter int MAX_RETRY = 3
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NPLL-1:0]                     LOCK,
  input  logic                                BPI_SEQ_IDLE,
  input  logic                                AL_DONE,
  input  logic                                ADC_RDY,
  input  logic                                RESTART_ALL,
  output logic [NPLL-1:0]                     PLL_RST,
  output logic                                POR,
  output logic                                ADC_INIT_RST,
  output logic                                AL_START,
  output logic                                RUN,
  output logic                                FAULT,
  output logic [retry_cnt_w(MAX_RETRY)-1:0]   RETRY_CNT,
  output logic [lock_stage_w(NPLL)-1:0]       LOCK_STAGE,
  output logic [3:0]                          POR_STATE
);

  localparam int RW = retry_cnt_w(MAX_RETRY);
  localparam int SW = lock_stage_w(NPLL);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NPLL - 1);

  logic [NPLL-1:0] lock_s1, lock_s2;
  por_state_t      state, nxt_state;
  logic [SW-1:0]   stage, nxt_stage;
  logic [RW-1:0]   retry, nxt_retry;
  logic            lower_lost;
  logic            timer_clr, timer_tc;
  logic [TW-1:0]   timer_tc_val;
  logic [NPLL-1:0] pll_rst_d;
  logic            por_d, adc_init_rst_d, al_start_d, run_d, fault_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
    end else begin
      lock_s1 <= LOCK;
      lock_s2 <= lock_s1;
    end
  end

  // One timer serves both dwells; which terminal count applies follows the state.
  assign timer_tc_val = (state == ST_W4LOCK) ? TW'(LOCK_TMO - 1) : TW'(POR_TMO - 1);
  assign timer_clr    = (nxt_state != state) || (nxt_stage != stage);

  por_timer #(.TW(TW)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (timer_clr),
    .tc_val (timer_tc_val),
    .tc     (timer_tc)
  );

  always_comb begin
    lower_lost = 1'b0;
    for (int j = 0; j < NPLL; j++)
      if (j < int'(stage) && !lock_s2[j]) lower_lost = 1'b1;
  end

  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    nxt_retry = retry;
    case (state)
      ST_IDLE: begin
        nxt_state = ST_W4LOCK;
        nxt_stage = '0;
      end
      ST_W4LOCK: begin
        // A lock seen on the timeout cycle wins over the timeout.
        if (lower_lost) begin
          nxt_state = ST_IDLE;
        end else if (lock_s2[stage]) begin
          if (stage == LAST_STAGE) nxt_state = ST_POR_HOLD;
          else                     nxt_stage = stage + 1'b1;
        end else if (timer_tc) begin
          if (retry == RETRY_MAX) begin
            nxt_state = ST_FAULT;
          end else begin
            nxt_state = ST_IDLE;
            nxt_retry = retry + 1'b1;
          end
        end
      end
      ST_POR_HOLD: begin
        if (!(&lock_s2))    nxt_state = ST_IDLE;
        else if (timer_tc)  nxt_state = ST_CNFG;
      end
      ST_CNFG:      if (BPI_SEQ_IDLE) nxt_state = ST_AUTO_LOAD;
      ST_AUTO_LOAD: if (AL_DONE)      nxt_state = ST_ADC_INIT;
      ST_ADC_INIT: begin
        if (ADC_RDY) begin
          nxt_state = ST_RUN;
          nxt_retry = '0;
        end
      end
      ST_RUN: begin
`ifdef POR_LOCK_MON_EN
        if (!(&lock_s2))     nxt_state = ST_IDLE;
        else if (RESTART_ALL) nxt_state = ST_POR_HOLD;
`else
        if (RESTART_ALL) nxt_state = ST_POR_HOLD;
`endif
      end
      ST_FAULT: begin
        if (RESTART_ALL) begin
          nxt_state = ST_IDLE;
          nxt_retry = '0;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move with POR_STATE.
  always_comb begin
    pll_rst_d = '0;
    for (int j = 0; j < NPLL; j++)
      pll_rst_d[j] = (nxt_state == ST_IDLE) || (nxt_state == ST_FAULT) ||
                     ((nxt_state == ST_W4LOCK) && (j > int'(nxt_stage)));
    por_d          = (nxt_state == ST_IDLE) || (nxt_state == ST_W4LOCK) ||
                     (nxt_state == ST_POR_HOLD) || (nxt_state == ST_FAULT);
    adc_init_rst_d = !((nxt_state == ST_ADC_INIT) || (nxt_state == ST_RUN));
    al_start_d     = (nxt_state == ST_AUTO_LOAD);
    run_d          = (nxt_state == ST_RUN);
    fault_d        = (nxt_state == ST_FAULT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      stage        <= '0;
      retry        <= '0;
      PLL_RST      <= '1;
      POR          <= 1'b1;
      ADC_INIT_RST <= 1'b1;
      AL_START     <= 1'b0;
      RUN          <= 1'b0;
      FAULT        <= 1'b0;
    end else begin
      state        <= nxt_state;
      stage        <= nxt_stage;
      retry        <= nxt_retry;
      PLL_RST      <= pll_rst_d;
      POR          <= por_d;
      ADC_INIT_RST <= adc_init_rst_d;
      AL_START     <= al_start_d;
      RUN          <= run_d;
      FAULT        <= fault_d;
    end
  end

  assign POR_STATE  = state;
  assign LOCK_STAGE = stage;
  assign RETRY_CNT  = retry;

endmodule

// File: tb/tb_por_sequencer.sv
module tb_por_sequencer;

  localparam int NPLL      = 2;
  localparam int POR_TMO   = 8;
  localparam int LOCK_TMO  = 20;
  localparam int MAX_RETRY = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NPLL-1:0] LOCK = '0;
  logic            BPI_SEQ_IDLE = 1'b0, AL_DONE = 1'b0, ADC_RDY = 1'b0, RESTART_ALL = 1'b0;
  logic [NPLL-1:0] PLL_RST;
  logic            POR, ADC_INIT_RST, AL_START, RUN, FAULT;
  logic [1:0]      RETRY_CNT;
  logic [0:0]      LOCK_STAGE;
  logic [3:0]      POR_STATE;

  int n_checks = 0;
  int n_pass   = 0;

  por_sequencer #(
    .NPLL(NPLL), .TW(16), .POR_TMO(POR_TMO), .LOCK_TMO(LOCK_TMO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK(CLK), .RST(RST), .LOCK(LOCK),
    .BPI_SEQ_IDLE(BPI_SEQ_IDLE), .AL_DONE(AL_DONE), .ADC_RDY(ADC_RDY), .RESTART_ALL(RESTART_ALL),
    .PLL_RST(PLL_RST), .POR(POR), .ADC_INIT_RST(ADC_INIT_RST), .AL_START(AL_START),
    .RUN(RUN), .FAULT(FAULT), .RETRY_CNT(RETRY_CNT), .LOCK_STAGE(LOCK_STAGE), .POR_STATE(POR_STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks mode, lock stage, retries and how many cycles have been spent in
  // the current mode/stage; LOCK is seen two edges after the pin.
  int m_state = 0, m_stage = 0, m_retry = 0, m_dwell = 1;
  logic [NPLL-1:0] m_seen = '0, m_prev = '0;

  function automatic logic [NPLL-1:0] exp_pll(input int st, input int stg);
    logic [NPLL-1:0] r;
    r = '0;
    for (int j = 0; j < NPLL; j++) r[j] = (st == 0) || (st == 7) || ((st == 1) && (j > stg));
    return r;
  endfunction

  initial begin
    forever begin
      int ns, nstg, nr;
      bit lower, all_lk;
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_state = 0; m_stage = 0; m_retry = 0; m_dwell = 1; m_seen = '0; m_prev = '0;
      end else begin
        ns = m_state; nstg = m_stage; nr = m_retry;
        all_lk = (m_seen == '1);
        lower = 1'b0;
        for (int j = 0; j < NPLL; j++) if (j < m_stage && !m_seen[j]) lower = 1'b1;
        case (m_state)
          0: begin ns = 1; nstg = 0; end
          1: begin
            if (lower) ns = 0;
            else if (m_seen[m_stage]) begin
              if (m_stage == NPLL - 1) ns = 2; else nstg = m_stage + 1;
            end else if (m_dwell == LOCK_TMO) begin
              if (m_retry == MAX_RETRY) ns = 7; else begin ns = 0; nr = m_retry + 1; end
            end
          end
          2: if (!all_lk) ns = 0; else if (m_dwell == POR_TMO) ns = 3;
          3: if (BPI_SEQ_IDLE) ns = 4;
          4: if (AL_DONE) ns = 5;
          5: if (ADC_RDY) begin ns = 6; nr = 0; end
          6: begin
`ifdef POR_LOCK_MON_EN
            if (!all_lk) ns = 0; else if (RESTART_ALL) ns = 2;
`else
            if (RESTART_ALL) ns = 2;
`endif
          end
          default: if (RESTART_ALL) begin ns = 0; nr = 0; end
        endcase
        m_dwell = (ns != m_state || nstg != m_stage) ? 1 : m_dwell + 1;
        m_state = ns; m_stage = nstg; m_retry = nr;
        m_seen = m_prev; m_prev = LOCK;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      chk("m_state", POR_STATE, m_state);
      chk("m_stage", LOCK_STAGE, m_stage);
      chk("m_retry", RETRY_CNT, m_retry);
      chk("m_pll_rst", PLL_RST, exp_pll(m_state, m_stage));
      chk("m_por", POR, (m_state <= 2 || m_state == 7) ? 1 : 0);
      chk("m_adc_init_rst", ADC_INIT_RST, (m_state == 5 || m_state == 6) ? 0 : 1);
      chk("m_al_start", AL_START, (m_state == 4) ? 1 : 0);
      chk("m_run", RUN, (m_state == 6) ? 1 : 0);
      chk("m_fault", FAULT, (m_state == 7) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: BPI_SEQ_IDLE = 1'b1;
      1: AL_DONE = 1'b1;
      2: ADC_RDY = 1'b1;
      default: RESTART_ALL = 1'b1;
    endcase
    tick();
    BPI_SEQ_IDLE = 1'b0; AL_DONE = 1'b0; ADC_RDY = 1'b0; RESTART_ALL = 1'b0;
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int n = 0;
    while (POR_STATE !== code && n < budget) begin tick(); n++; end
    chk(name, POR_STATE, code);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, POR_STATE, 0);
    chk({tag, "_pll_rst"}, PLL_RST, 2'b11);
    chk({tag, "_por"}, POR, 1);
    chk({tag, "_adc_init_rst"}, ADC_INIT_RST, 1);
    chk({tag, "_al_start"}, AL_START, 0);
    chk({tag, "_run"}, RUN, 0);
    chk({tag, "_fault"}, FAULT, 0);
    chk({tag, "_retry"}, RETRY_CNT, 0);
    chk({tag, "_stage"}, LOCK_STAGE, 0);
  endtask

  task automatic count_hold();
    int n = 0;
    wait_state(2, 60, "reach_por_hold");
    while (POR_STATE === 4'd2 && n < 50) begin
      if (POR === 1'b1 && ADC_INIT_RST === 1'b1 && RUN === 1'b0) n++;
      tick();
    end
    chk("por_hold_cycles", n, POR_TMO);
    chk("cnfg_after_hold", POR_STATE, 3);
    chk("por_low_in_cnfg", POR, 0);
  endtask

  task automatic run_through();
    wait_state(3, 20, "reach_cnfg");
    pulse(0);
    chk("autoload_state", POR_STATE, 4);
    chk("al_start_high", AL_START, 1);
    pulse(1);
    chk("adc_init_state", POR_STATE, 5);
    chk("adc_init_rst_low", ADC_INIT_RST, 0);
    pulse(2);
    chk("run_state", POR_STATE, 6);
    chk("run_high", RUN, 1);
    chk("run_retry_zero", RETRY_CNT, 0);
  endtask

  task automatic wait_stage1(input int budget);
    int n = 0;
    while (!(POR_STATE === 4'd1 && LOCK_STAGE === 1'b1) && n < budget) begin tick(); n++; end
    chk("reach_stage1", {POR_STATE, 3'b000, LOCK_STAGE}, {4'd1, 4'd1});
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [NPLL-1:0] seq[$];
    int n, rate;

    repeat (3) tick();
    chk_reset_vals("reset");

    // Nominal bring-up
    RST = 1'b0;
    seq.push_back(PLL_RST);
    for (int c = 1; c <= 60 && POR_STATE !== 4'd2; c++) begin
      if (c == 5)  LOCK[0] = 1'b1;
      if (c == 12) LOCK[1] = 1'b1;
      tick();
      if (PLL_RST !== seq[$]) seq.push_back(PLL_RST);
    end
    chk("pll_rst_steps", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("pll_rst_seq0", seq[0], 2'b11);
      chk("pll_rst_seq1", seq[1], 2'b10);
      chk("pll_rst_seq2", seq[2], 2'b00);
    end
    count_hold();
    run_through();

    // Restart from Run
    pulse(3);
    count_hold();
    run_through();

    // Lock drop in POR_Hold: pin low in dwell cycle 2, seen in cycle 4
    pulse(3);
    tick();
    LOCK[0] = 1'b0;
    tick();
    tick();
    chk("hold_dwell4_still_hold", POR_STATE, 2);
    tick();
    chk("hold_lockdrop_idle", POR_STATE, 0);
    chk("hold_lockdrop_pll_rst", PLL_RST, 2'b11);
    chk("hold_lockdrop_retry", RETRY_CNT, 0);
    LOCK[0] = 1'b1;
    count_hold();
    run_through();

    // Lock arriving on the timeout cycle wins
    pulse(3);
    LOCK[1] = 1'b0;
    wait_stage1(40);
    repeat (17) tick();
    LOCK[1] = 1'b1;
    tick();
    tick();
    chk("race_cycle20_stage1", POR_STATE, 1);
    tick();
    chk("race_lock_wins", POR_STATE, 2);
    chk("race_no_retry", RETRY_CNT, 0);
    count_hold();
    run_through();

    // Timeouts, retries, fault
    pulse(3);
    LOCK[1] = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      wait_stage1(40);
      n = 0;
      while (POR_STATE === 4'd1 && LOCK_STAGE === 1'b1 && n < 60) begin n++; tick(); end
      chk("stage1_dwell", n, LOCK_TMO);
      if (r < 3) begin
        chk("timeout_idle", POR_STATE, 0);
        chk("timeout_retry", RETRY_CNT, r);
      end
    end
    chk("fault_state", POR_STATE, 7);
    chk("fault_flag", FAULT, 1);
    chk("fault_stage", LOCK_STAGE, 1);
    chk("fault_pll_rst", PLL_RST, 2'b11);
    chk("fault_por", POR, 1);
    LOCK[1] = 1'b1;
    repeat (5) tick();
    chk("fault_sticky", POR_STATE, 7);
    pulse(3);
    chk("fault_restart_idle", POR_STATE, 0);
    chk("fault_restart_flag", FAULT, 0);
    chk("fault_restart_retry", RETRY_CNT, 0);
    count_hold();
    run_through();

    // Lock loss while running
    LOCK[0] = 1'b0;
    repeat (3) tick();
`ifdef POR_LOCK_MON_EN
    chk("mon_idle", POR_STATE, 0);
    chk("mon_run_low", RUN, 0);
    chk("mon_pll_rst", PLL_RST, 2'b11);
    LOCK[0] = 1'b1;
    count_hold();
    run_through();
`else
    repeat (3) tick();
    chk("nomon_still_run", POR_STATE, 6);
    chk("nomon_run_high", RUN, 1);
    LOCK[0] = 1'b1;
    tick();
`endif

    // Asynchronous reset in Auto_Load
    pulse(3);
    count_hold();
    pulse(0);
    chk("pre_rst_autoload", POR_STATE, 4);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    RST = 1'b0;
    count_hold();
    run_through();

    // Randomised traffic against the model
    rate = 8;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rate = (c % 1500 == 0) ? 40 : ((c % 1000 == 0) ? 2 : 8);
      for (int j = 0; j < NPLL; j++) begin
        if (LOCK[j] && $urandom_range(0, 59) == 0) LOCK[j] = 1'b0;
        else if (!LOCK[j] && $urandom_range(0, rate - 1) == 0) LOCK[j] = 1'b1;
      end
      BPI_SEQ_IDLE = ($urandom_range(0, 2) == 0);
      AL_DONE      = ($urandom_range(0, 2) == 0);
      ADC_RDY      = ($urandom_range(0, 2) == 0);
      RESTART_ALL  = ($urandom_range(0, 24) == 0);
      RST          = ($urandom_range(0, 1499) == 0);
      tick();
    end
    RST = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
